// File: rtl/bias_act_stage_pkg.sv
// Shared lane constants and arithmetic helpers for the bias/activation stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bias_act_stage_pkg;

  localparam int LANE_IN_W  = 18;
  localparam int LANE_OUT_W = 16;
  // Working width for shift/clamp math; comfortably wider than any lane sum.
  localparam int CALC_W     = 64;

  // Width of the group index; a single-group build still gets a 1-bit index.
  function automatic int grp_w(input int n_groups);
    return (n_groups > 1) ? $clog2(n_groups) : 1;
  endfunction

  // Arithmetic shift (floor), optional ReLU, then clamp to a signed out_w range.
  function automatic logic signed [CALC_W-1:0] shift_sat(
    input logic signed [CALC_W-1:0] s,
    input int                       shift,
    input int                       out_w,
    input logic                     relu
  );
    logic signed [CALC_W-1:0] t;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    t  = s >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (relu && (t < 64'sd0)) t = '0;
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return t;
  endfunction

endpackage

// File: rtl/bias_act_lane.sv
// One lane: bias add (stage-1 input) and shift/ReLU/saturate (stage-2 input); ReLU built in when BIAS_ACT_RELU_EN is defined.
// Latency: 0 cycles, purely combinational; the top owns both pipeline registers.
// Backpressure: none, the top only registers results when its handshake allows.
module bias_act_lane
  import bias_act_stage_pkg::*;
#(
  parameter int IN_W  = LANE_IN_W,
  parameter int OUT_W = LANE_OUT_W,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0]  sum_in,
  input  logic signed [IN_W-1:0]  bias_in,
  output logic signed [IN_W:0]    s_out,
  input  logic signed [IN_W:0]    s_in,
  output logic signed [OUT_W-1:0] act_out
);

`ifdef BIAS_ACT_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  logic signed [CALC_W-1:0] s_ext;

  // Bias add with one guard bit so the sum can never wrap.
  always_comb begin
    s_out = {sum_in[IN_W-1], sum_in} + {bias_in[IN_W-1], bias_in};
  end

  // Sign-extend the registered sum, then shift, optionally rectify, and clamp.
  always_comb begin
    s_ext   = {{(CALC_W-IN_W-1){s_in[IN_W]}}, s_in};
    act_out = OUT_W'(shift_sat(s_ext, SHIFT, OUT_W, RELU));
  end

endmodule

// File: rtl/bias_act_stage.sv
// Bias add + shift + (ReLU if BIAS_ACT_RELU_EN) + saturate over N_adder_tree lanes, with channel-group tagging.
// Latency: 2 cycles input handshake to out_valid; 1 beat/cycle with out_ready high.
// Backpressure: registered in_ready; stage-1 reg, output reg and a 1-entry skid absorb beats in flight.
module bias_act_stage
  import bias_act_stage_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int IN_W         = LANE_IN_W,
  parameter int OUT_W        = LANE_OUT_W,
  parameter int SHIFT        = 2,
  parameter int N_GROUPS     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_adder_tree*IN_W-1:0]   sum_in,
  input  logic [N_adder_tree*IN_W-1:0]   bias_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N_adder_tree*OUT_W-1:0]  act_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [grp_w(N_GROUPS)-1:0]     group_idx,
  output logic                           last_group
);

  localparam int N  = N_adder_tree;
  localparam int SW = IN_W + 1;
  localparam int GW = grp_w(N_GROUPS);
  localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);

  logic [N*SW-1:0]    s_new;
  logic [N*OUT_W-1:0] act_new;

  logic               in_ready_q,  in_ready_d;
  logic               s1_vld_q,    s1_vld_d;
  logic [N*SW-1:0]    s1_dat_q,    s1_dat_d;
  logic               out_vld_q,   out_vld_d;
  logic [N*OUT_W-1:0] act_q,       act_d;
  logic               skid_vld_q,  skid_vld_d;
  logic [N*OUT_W-1:0] skid_dat_q,  skid_dat_d;
  logic [GW-1:0]      grp_q,       grp_d;

  logic in_fire;
  logic out_fire;
  logic s1_move;

  for (genvar i = 0; i < N; i++) begin : g_lane
    bias_act_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .sum_in  (sum_in[i*IN_W +: IN_W]),
      .bias_in (bias_in[i*IN_W +: IN_W]),
      .s_out   (s_new[i*SW +: SW]),
      .s_in    (s1_dat_q[i*SW +: SW]),
      .act_out (act_new[i*OUT_W +: OUT_W])
    );
  end

  // Ordered three-slot pipeline: output reg is oldest, skid next, stage-1 youngest.
  always_comb begin
    in_fire    = in_valid && in_ready_q;
    out_fire   = out_vld_q && out_ready;
    s1_move    = 1'b0;
    s1_vld_d   = s1_vld_q;
    s1_dat_d   = s1_dat_q;
    out_vld_d  = out_vld_q;
    act_d      = act_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    grp_d      = grp_q;

    // Drain: the skid entry (older than stage 1) becomes the new head.
    if (out_fire) begin
      out_vld_d  = skid_vld_q;
      if (skid_vld_q) act_d = skid_dat_q;
      skid_vld_d = 1'b0;
      grp_d      = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
    end

    // Stage 1 moves into the first free downstream slot, else it holds.
    if (s1_vld_q) begin
      if (!out_vld_d) begin
        out_vld_d = 1'b1;
        act_d     = act_new;
        s1_move   = 1'b1;
      end else if (!skid_vld_d) begin
        skid_vld_d = 1'b1;
        skid_dat_d = act_new;
        s1_move    = 1'b1;
      end
    end

    // in_ready was only granted when stage 1 is free or guaranteed to move.
    if (!s1_vld_q || s1_move) begin
      s1_vld_d = in_fire;
      if (in_fire) s1_dat_d = s_new;
    end

    // Offer a slot next cycle only if one stays free even if out_ready stalls.
    in_ready_d = !(s1_vld_d && out_vld_d && skid_vld_d);
  end

  // Pipeline, skid and group state; reset discards every beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      out_vld_q  <= 1'b0;
      act_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      grp_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= s1_dat_d;
      out_vld_q  <= out_vld_d;
      act_q      <= act_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      grp_q      <= grp_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_vld_q;
  assign act_out    = act_q;
  assign group_idx  = grp_q;
  assign last_group = out_vld_q && (grp_q == LAST_GRP);

endmodule

// File: tb/tb_bias_act_stage.sv
// Directed and randomized checks of bias_act_stage (build-aware of BIAS_ACT_RELU_EN).
// Latency: checks the 2-cycle input-to-output timing.
// Backpressure: exercises stalls, skid fill/drain and random out_ready.
`timescale 1ns/1ps
module tb_bias_act_stage;

  localparam int N     = 16;
  localparam int IN_W  = 18;
  localparam int OUT_W = 16;
  localparam int SHIFT = 2;
  localparam int NG    = 8;
  localparam int GW    = 3;

`ifdef BIAS_ACT_RELU_EN
  localparam logic [OUT_W-1:0] EXP_L1 = 16'h0000;
  localparam logic [OUT_W-1:0] EXP_L3 = 16'h0000;
  localparam logic [OUT_W-1:0] EXP_L5 = 16'h0000;
`else
  localparam logic [OUT_W-1:0] EXP_L1 = 16'hFFC0;
  localparam logic [OUT_W-1:0] EXP_L3 = 16'h8000;
  localparam logic [OUT_W-1:0] EXP_L5 = 16'hFFFF;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N*IN_W-1:0]    sum_in;
  logic [N*IN_W-1:0]    bias_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*OUT_W-1:0]   act_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [GW-1:0]        group_idx;
  logic                 last_group;

  int checks = 0;
  int passed = 0;

  bias_act_stage #(
    .N_adder_tree (N),
    .IN_W         (IN_W),
    .OUT_W        (OUT_W),
    .SHIFT        (SHIFT),
    .N_GROUPS     (NG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_in     (sum_in),
    .bias_in    (bias_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .act_out    (act_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .group_idx  (group_idx),
    .last_group (last_group)
  );

  always #5 clk = ~clk;

  // Reference: integer add, floor shift, optional ReLU, clamp to 16-bit signed.
  function automatic logic [N*OUT_W-1:0] model(input logic [N*IN_W-1:0] s,
                                              input logic [N*IN_W-1:0] b);
    logic [N*OUT_W-1:0]     r;
    logic signed [IN_W-1:0] a;
    logic signed [IN_W-1:0] c;
    int                     t;
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = s[i*IN_W +: IN_W];
      c = b[i*IN_W +: IN_W];
      t = (int'(a) + int'(c)) >>> SHIFT;
`ifdef BIAS_ACT_RELU_EN
      if (t < 0) t = 0;
`endif
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      r[i*OUT_W +: OUT_W] = t[OUT_W-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    bias_in   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    bias_in   = '0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
    checks++; if (act_out !== '0) $display("FAIL rst_act_out got %h want 0", act_out); else passed++;
    checks++; if (group_idx !== 3'd0) $display("FAIL rst_group_idx got %0d want 0", group_idx); else passed++;
    checks++; if (last_group !== 1'b0) $display("FAIL rst_last_group got %b want 0", last_group); else passed++;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_early got %b want 0", in_ready); else passed++;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready_first_edge got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_vectors();
    logic [OUT_W-1:0]   exp_l [6];
    logic [N*OUT_W-1:0] held;
    exp_l = '{16'h0048, EXP_L1, 16'h7FFF, EXP_L3, 16'h0001, EXP_L5};
    out_ready = 1'b1;
    sum_in  = '0;
    bias_in = '0;
    sum_in[0*IN_W +: IN_W]  = 18'h00100;  bias_in[0*IN_W +: IN_W] = 18'h00020;
    sum_in[1*IN_W +: IN_W]  = 18'h3FF00;
    sum_in[2*IN_W +: IN_W]  = 18'h1FFFF;  bias_in[2*IN_W +: IN_W] = 18'h1FFFF;
    sum_in[3*IN_W +: IN_W]  = 18'h20000;  bias_in[3*IN_W +: IN_W] = 18'h20000;
    sum_in[4*IN_W +: IN_W]  = 18'h00007;
    sum_in[5*IN_W +: IN_W]  = 18'h3FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL lat_cycle1 out_valid got %b want 0", out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL lat_cycle2 out_valid got %b want 1", out_valid); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (act_out[i*OUT_W +: OUT_W] !== exp_l[i])
        $display("FAIL vec_lane%0d got %h want %h", i, act_out[i*OUT_W +: OUT_W], exp_l[i]);
      else passed++;
    end
    checks++; if (act_out !== model(sum_in, bias_in)) $display("FAIL vec_all got %h want %h", act_out, model(sum_in, bias_in)); else passed++;
    checks++; if (group_idx !== 3'd0) $display("FAIL vec_group got %0d want 0", group_idx); else passed++;
    held = act_out;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL vec_drained out_valid got %b want 0", out_valid); else passed++;
    checks++; if (act_out !== held) $display("FAIL vec_hold act_out got %h want %h", act_out, held); else passed++;
    checks++; if (group_idx !== 3'd1) $display("FAIL vec_group_adv got %0d want 1", group_idx); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int first_cyc;
    int last_cyc;
    apply_reset();
    out_ready = 1'b1;
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        checks++;
        if (group_idx !== GW'(got % NG) || last_group !== ((got % NG) == NG - 1) ||
            act_out[0 +: OUT_W] !== OUT_W'(got))
          $display("FAIL b2b_beat%0d got grp=%0d last=%b lane0=%h want grp=%0d last=%b lane0=%h",
                   got, group_idx, last_group, act_out[0 +: OUT_W], got % NG,
                   (got % NG) == NG - 1, OUT_W'(got));
        else passed++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (sent < 17) begin
        in_valid = 1'b1;
        sum_in   = '0;
        bias_in  = '0;
        sum_in[0 +: IN_W]  = IN_W'(sent * 4);
        bias_in[0 +: IN_W] = 18'd2;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready beat%0d got %b want 1", sent, in_ready); else passed++;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    checks++; if (got !== 17) $display("FAIL b2b_count got %0d want 17", got); else passed++;
    checks++; if (first_cyc !== 2) $display("FAIL b2b_first_cycle got %0d want 2", first_cyc); else passed++;
    checks++; if (last_cyc - first_cyc !== 16) $display("FAIL b2b_span got %0d want 16", last_cyc - first_cyc); else passed++;
  endtask

  task automatic test_stall();
    int acc;
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    bias_in   = '0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      sum_in = '0;
      sum_in[0 +: IN_W] = IN_W'(acc * 4);
      if (in_ready) acc++;
      tick();
    end
    checks++; if (acc !== 3) $display("FAIL stall_accepted got %0d want 3", acc); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid got %b want 1", out_valid); else passed++;
    checks++; if (act_out[0 +: OUT_W] !== 16'd0) $display("FAIL stall_head got %h want 0000", act_out[0 +: OUT_W]); else passed++;
    checks++; if (group_idx !== 3'd0) $display("FAIL stall_group got %0d want 0", group_idx); else passed++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL drain_same_cycle in_ready got %b want 0", in_ready); else passed++;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL drain_next_cycle in_ready got %b want 1", in_ready); else passed++;
    checks++; if (act_out[0 +: OUT_W] !== 16'd1 || group_idx !== 3'd1)
      $display("FAIL drain_beat1 got lane0=%h grp=%0d want 0001 grp=1", act_out[0 +: OUT_W], group_idx); else passed++;
    tick();
    checks++; if (act_out[0 +: OUT_W] !== 16'd2 || group_idx !== 3'd2 || out_valid !== 1'b1)
      $display("FAIL drain_beat2 got lane0=%h grp=%0d vld=%b want 0002 grp=2 vld=1", act_out[0 +: OUT_W], group_idx, out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0 || act_out[0 +: OUT_W] !== 16'd2)
      $display("FAIL drain_empty got vld=%b lane0=%h want vld=0 lane0=0002", out_valid, act_out[0 +: OUT_W]); else passed++;
  endtask

  task automatic test_random();
    logic [N*OUT_W-1:0] exp_q[$];
    logic [N*OUT_W-1:0] exp_v;
    int  sent;
    int  rcvd;
    int  comb_bad;
    logic r0;
    apply_reset();
    sent = 0; rcvd = 0; comb_bad = 0;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        sum_in[i*IN_W +: IN_W]  = IN_W'($urandom);
        bias_in[i*IN_W +: IN_W] = IN_W'($urandom);
      end
      r0 = in_ready;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_ready !== r0) comb_bad++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(sum_in, bias_in));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra_beat got beat %0d want none queued", rcvd);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_out !== exp_v || group_idx !== GW'(rcvd % NG))
            $display("FAIL rnd_beat%0d got %h grp=%0d want %h grp=%0d", rcvd, act_out, group_idx, exp_v, rcvd % NG);
          else passed++;
        end
        rcvd++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (rcvd !== 1000) $display("FAIL rnd_received got %0d want 1000", rcvd); else passed++;
    checks++; if (sent !== 1000) $display("FAIL rnd_sent got %0d want 1000", sent); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL rnd_leftover got %0d want 0", exp_q.size()); else passed++;
    checks++; if (comb_bad !== 0) $display("FAIL rnd_in_ready_comb got %0d changes want 0", comb_bad); else passed++;
  endtask

  task automatic test_reset_midflight();
    int stale;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_in    = '0;
    bias_in   = '0;
    sum_in[0 +: IN_W] = 18'h00040;
    tick();
    sum_in[0 +: IN_W] = 18'h00080;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL mid_inflight out_valid got %b want 1", out_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b want 0", in_ready); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) $display("FAIL mid_stale_beats got %0d want 0", stale); else passed++;
    checks++; if (group_idx !== 3'd0) $display("FAIL mid_group got %0d want 0", group_idx); else passed++;
    checks++; if (act_out !== '0) $display("FAIL mid_act_out got %h want 0", act_out); else passed++;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    bias_in   = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
